// File: rtl/operator_tx_mux.sv
// rtl/operator_tx_mux.sv - CSR-selected Tx channel arbiter between the MPF shim and N query operators.
// A new operator is granted c0/c1 only after the outgoing operator's traffic drains; c2 follows cur_sel always.
module operator_tx_mux #(
  parameter int N_OPS         = 4,
  parameter int C0_W          = 256,
  parameter int C1_W          = 768,
  parameter int C2_W          = 80,
  parameter int DONE_CODE     = 5,
  parameter int RESET_SEL     = 0,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_sel_en,
  input  logic [7:0]              csr_sel_data,
  input  logic [N_OPS-1:0]        op_c0_valid,
  input  logic [N_OPS*C0_W-1:0]   op_c0_req,
  input  logic [N_OPS-1:0]        op_c1_valid,
  input  logic [N_OPS*C1_W-1:0]   op_c1_req,
  input  logic [N_OPS-1:0]        op_c2_valid,
  input  logic [N_OPS*C2_W-1:0]   op_c2_rsp,
  input  logic                    fiu_c0TxAlmFull,
  input  logic                    fiu_c1TxAlmFull,
  input  logic                    c0NotEmpty,
  input  logic                    c1NotEmpty,
  output logic                    fiu_c0_valid,
  output logic [C0_W-1:0]         fiu_c0_req,
  output logic                    fiu_c1_valid,
  output logic [C1_W-1:0]         fiu_c1_req,
  output logic                    fiu_c2_valid,
  output logic [C2_W-1:0]         fiu_c2_rsp,
  output logic [N_OPS-1:0]        op_c0AlmFull,
  output logic [N_OPS-1:0]        op_c1AlmFull,
  output logic [N_OPS-1:0]        op_active,
  output logic [N_OPS-1:0]        op_start,
  output logic [2:0]              cur_sel,
  output logic                    busy,
  output logic                    sel_error,
  output logic                    drain_timeout
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_SWITCH, ST_IDLE} state_t;

  localparam int              CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
  localparam logic [7:0]      N_OPS_B   = 8'(N_OPS);
  localparam logic [7:0]      DONE_B    = 8'(DONE_CODE);
  localparam logic [2:0]      RESET_IDX = 3'(RESET_SEL);

  function automatic logic [N_OPS-1:0] onehot(input logic [2:0] idx);
    logic [N_OPS-1:0] v;
    v = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (idx == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cur_sel_q, cur_sel_d;
  logic [2:0]        pend_sel_q, pend_sel_d;
  logic              pend_idle_q, pend_idle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_OPS-1:0]  op_active_q, op_active_d;
  logic [N_OPS-1:0]  op_start_q, op_start_d;
  logic              busy_q, busy_d;
  logic              sel_error_q, sel_error_d;
  logic              drain_timeout_q, drain_timeout_d;
  logic              fiu_c0_valid_q, fiu_c0_valid_d;
  logic              fiu_c1_valid_q, fiu_c1_valid_d;
  logic              fiu_c2_valid_q, fiu_c2_valid_d;
  logic [C0_W-1:0]   fiu_c0_req_q, fiu_c0_req_d;
  logic [C1_W-1:0]   fiu_c1_req_q, fiu_c1_req_d;
  logic [C2_W-1:0]   fiu_c2_rsp_q, fiu_c2_rsp_d;

  logic              cur_c0_valid, cur_c1_valid, cur_c2_valid;
  logic              sel_valid, sel_done, sel_bad;
  logic [2:0]        sel_idx;

  always_comb begin
    cur_c0_valid = 1'b0;
    cur_c1_valid = 1'b0;
    cur_c2_valid = 1'b0;
    fiu_c0_req_d = '0;
    fiu_c1_req_d = '0;
    fiu_c2_rsp_d = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (cur_sel_q == 3'(i)) begin
        cur_c0_valid = op_c0_valid[i];
        cur_c1_valid = op_c1_valid[i];
        cur_c2_valid = op_c2_valid[i];
        fiu_c0_req_d = op_c0_req[i*C0_W +: C0_W];
        fiu_c1_req_d = op_c1_req[i*C1_W +: C1_W];
        fiu_c2_rsp_d = op_c2_rsp[i*C2_W +: C2_W];
      end
    end
  end

  // A value that is both < N_OPS and DONE_CODE is treated as an operator index.
  always_comb begin
    sel_valid = csr_sel_en && (csr_sel_data < N_OPS_B);
    sel_done  = csr_sel_en && !sel_valid && (csr_sel_data == DONE_B);
    sel_bad   = csr_sel_en && !sel_valid && !sel_done;
    sel_idx   = csr_sel_data[2:0];
  end

  always_comb begin
    state_d         = state_q;
    cur_sel_d       = cur_sel_q;
    pend_sel_d      = pend_sel_q;
    pend_idle_d     = pend_idle_q;
    cnt_d           = cnt_q;
    op_start_d      = '0;
    sel_error_d     = sel_error_q | sel_bad;
    drain_timeout_d = drain_timeout_q;

    unique case (state_q)
      ST_ACTIVE: begin
        if ((sel_valid && (sel_idx != cur_sel_q)) || sel_done) begin
          pend_sel_d  = sel_idx;
          pend_idle_d = sel_done;
          cnt_d       = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_IDLE: begin
        if (sel_valid) begin
          pend_sel_d  = sel_idx;
          pend_idle_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sel_valid || sel_done) begin
          pend_sel_d  = sel_idx;
          pend_idle_d = sel_done;
        end
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // First DRAIN cycle still carries the last forwarded request, so NotEmpty is not trusted yet.
        if ((cnt_q != '0) && !c0NotEmpty && !c1NotEmpty) begin
          state_d = ST_SWITCH;
        end else if (cnt_d == CNT_MAX) begin
          state_d         = ST_SWITCH;
          drain_timeout_d = 1'b1;
        end
      end
      ST_SWITCH: begin
        if (pend_idle_q) begin
          state_d = ST_IDLE;
        end else begin
          cur_sel_d  = pend_sel_q;
          op_start_d = onehot(pend_sel_q);
          state_d    = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    op_active_d    = (state_d == ST_ACTIVE) ? onehot(cur_sel_d) : '0;
    busy_d         = (state_d == ST_DRAIN) || (state_d == ST_SWITCH);
    fiu_c0_valid_d = (state_q == ST_ACTIVE) && cur_c0_valid;
    fiu_c1_valid_d = (state_q == ST_ACTIVE) && cur_c1_valid;
    fiu_c2_valid_d = cur_c2_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_ACTIVE;
      cur_sel_q       <= RESET_IDX;
      pend_sel_q      <= '0;
      pend_idle_q     <= 1'b0;
      cnt_q           <= '0;
      op_active_q     <= onehot(RESET_IDX);
      op_start_q      <= '0;
      busy_q          <= 1'b0;
      sel_error_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
      fiu_c0_valid_q  <= 1'b0;
      fiu_c1_valid_q  <= 1'b0;
      fiu_c2_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_sel_q       <= cur_sel_d;
      pend_sel_q      <= pend_sel_d;
      pend_idle_q     <= pend_idle_d;
      cnt_q           <= cnt_d;
      op_active_q     <= op_active_d;
      op_start_q      <= op_start_d;
      busy_q          <= busy_d;
      sel_error_q     <= sel_error_d;
      drain_timeout_q <= drain_timeout_d;
      fiu_c0_valid_q  <= fiu_c0_valid_d;
      fiu_c1_valid_q  <= fiu_c1_valid_d;
      fiu_c2_valid_q  <= fiu_c2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    fiu_c0_req_q <= fiu_c0_req_d;
    fiu_c1_req_q <= fiu_c1_req_d;
    fiu_c2_rsp_q <= fiu_c2_rsp_d;
  end

  always_comb begin
    op_c0AlmFull = '1;
    op_c1AlmFull = '1;
    for (int i = 0; i < N_OPS; i++) begin
      if ((state_q == ST_ACTIVE) && (cur_sel_q == 3'(i))) begin
        op_c0AlmFull[i] = fiu_c0TxAlmFull;
        op_c1AlmFull[i] = fiu_c1TxAlmFull;
      end
    end
  end

  assign fiu_c0_valid  = fiu_c0_valid_q;
  assign fiu_c0_req    = fiu_c0_req_q;
  assign fiu_c1_valid  = fiu_c1_valid_q;
  assign fiu_c1_req    = fiu_c1_req_q;
  assign fiu_c2_valid  = fiu_c2_valid_q;
  assign fiu_c2_rsp    = fiu_c2_rsp_q;
  assign op_active     = op_active_q;
  assign op_start      = op_start_q;
  assign cur_sel       = cur_sel_q;
  assign busy          = busy_q;
  assign sel_error     = sel_error_q;
  assign drain_timeout = drain_timeout_q;

endmodule
